// File: rtl/fcims_order_controller_if.sv
// Kiosk-side bus of the order controller: per-requester requests plus shared results.
// Handshake: a requester raises req with stable op/qty, and keeps req high until its own gnt
// bit is set and the done pulse has been consumed; dropping req then ends the grant.
interface fcims_order_controller_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N-1:0]   op;
    logic [4*N-1:0] qty;
    logic           price_we;
    logic [3:0]     price_in;
    logic [N-1:0]   gnt;
    logic           done;
    logic           ok;
    logic [7:0]     fprice;
    logic [3:0]     stock;
    logic [3:0]     uprice;
    logic [11:0]    total_sales;
    logic [1:0]     fsm_state;

    modport master (
        output req, op, qty, price_we, price_in,
        input  gnt, done, ok, fprice, stock, uprice, total_sales, fsm_state
    );

    modport slave (
        input  req, op, qty, price_we, price_in,
        output gnt, done, ok, fprice, stock, uprice, total_sales, fsm_state
    );
endinterface

// File: rtl/fcims_order_controller.sv
// Round-robin sequencer of sell/restock orders onto a shared stock/price datapath,
// with a one-cycle execute step and a grant held until the winner releases req.
module fcims_order_controller #(
    parameter int         N          = 4,
    parameter logic [3:0] STOCK_INIT = 4'd10,
    parameter logic [3:0] PRICE_INIT = 4'd3
) (
    input logic clk,
    input logic rst,
    fcims_order_controller_if.slave bus
);
    localparam int PW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt;
    logic [PW-1:0]   win, win_nxt;
    logic [PW-1:0]   pick;
    logic            found;
    logic [PW:0]     cand;
    logic            lat_op, lat_op_nxt;
    logic [3:0]      lat_qty, lat_qty_nxt;
    logic [N-1:0]    gnt_q, gnt_nxt;
    logic            done_q, done_nxt;
    logic            ok_q, ok_nxt;
    logic [7:0]      fprice_q, fprice_nxt;
    logic [3:0]      stock_q, stock_nxt;
    logic [3:0]      uprice_q;
    logic [11:0]     sales_q, sales_nxt;
    logic [4:0]      restock_sum;
    logic [7:0]      product;
    logic [12:0]     sales_sum;

    // Rotating priority: scan from rr_ptr upward, wrapping at N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (!found && bus.req[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        restock_sum = {1'b0, stock_q} + {1'b0, lat_qty};
        product     = {4'b0, uprice_q} * {4'b0, lat_qty};
        sales_sum   = {1'b0, sales_q} + {5'b0, product};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = WAIT;
            WAIT:    if (!bus.req[win]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = gnt_q;
        done_nxt    = 1'b0;
        ok_nxt      = ok_q;
        fprice_nxt  = fprice_q;
        stock_nxt   = stock_q;
        sales_nxt   = sales_q;
        rr_nxt      = rr_ptr;
        win_nxt     = win;
        lat_op_nxt  = lat_op;
        lat_qty_nxt = lat_qty;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    win_nxt       = pick;
                    lat_op_nxt    = bus.op[pick];
                    lat_qty_nxt   = bus.qty[{pick, 2'b00} +: 4];
                end
            end
            EXEC: begin
                done_nxt   = 1'b1;
                fprice_nxt = '0;
                rr_nxt     = (win == PW'(N-1)) ? '0 : win + PW'(1);
                // Any result that would not fit is rejected, leaving stock untouched.
                if (!lat_op) begin
                    if (lat_qty <= stock_q) begin
                        stock_nxt  = stock_q - lat_qty;
                        fprice_nxt = product;
                        sales_nxt  = (sales_sum > 13'd4095) ? 12'hFFF : sales_sum[11:0];
                        ok_nxt     = 1'b1;
                    end else begin
                        ok_nxt = 1'b0;
                    end
                end else begin
                    if (!restock_sum[4]) begin
                        stock_nxt = restock_sum[3:0];
                        ok_nxt    = 1'b1;
                    end else begin
                        ok_nxt = 1'b0;
                    end
                end
            end
            WAIT:    if (!bus.req[win]) gnt_nxt = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q    <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            fprice_q <= '0;
            stock_q  <= STOCK_INIT;
            sales_q  <= '0;
            rr_ptr   <= '0;
            win      <= '0;
            lat_op   <= 1'b0;
            lat_qty  <= '0;
        end else begin
            gnt_q    <= gnt_nxt;
            done_q   <= done_nxt;
            ok_q     <= ok_nxt;
            fprice_q <= fprice_nxt;
            stock_q  <= stock_nxt;
            sales_q  <= sales_nxt;
            rr_ptr   <= rr_nxt;
            win      <= win_nxt;
            lat_op   <= lat_op_nxt;
            lat_qty  <= lat_qty_nxt;
        end
    end

    // Price writes land on any edge; EXEC already sampled the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               uprice_q <= PRICE_INIT;
        else if (bus.price_we) uprice_q <= bus.price_in;
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.ok          = ok_q;
    assign bus.fprice      = fprice_q;
    assign bus.stock       = stock_q;
    assign bus.uprice      = uprice_q;
    assign bus.total_sales = sales_q;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_fcims_order_controller.sv
// Bench for fcims_order_controller: directed scenarios then random orders, all checked
// through an expected queue against an arithmetic model of stock, price and sales.
module tb_fcims_order_controller;
    localparam int N = 4;
    localparam int W = N + 29;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fcims_order_controller_if #(.N(N)) bus ();

    fcims_order_controller #(
        .N(N), .STOCK_INIT(4'd10), .PRICE_INIT(4'd3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act, mon_exp;

    int m_stock, m_price, m_sales, m_rr;
    bit pend[N];
    int p_op[N], p_qty[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected transaction.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            mon_act = {bus.gnt, bus.ok, bus.fprice, bus.stock, bus.uprice, bus.total_sales};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got done with no pending expectation act=%h", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL txn: got gnt=%b ok=%b fprice=%0d stock=%0d uprice=%0d sales=%0d expected gnt=%b ok=%b fprice=%0d stock=%0d uprice=%0d sales=%0d",
                             mon_act[W-1 -: N], mon_act[28], mon_act[27:20], mon_act[19:16], mon_act[15:12], mon_act[11:0],
                             mon_exp[W-1 -: N], mon_exp[28], mon_exp[27:20], mon_exp[19:16], mon_exp[15:12], mon_exp[11:0]);
                end
            end
        end
    end

    function automatic void model_reset();
        m_stock = 10;
        m_price = 3;
        m_sales = 0;
        m_rr    = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endfunction

    function automatic int predict();
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_exec(input int w, input int exec_price);
        int q, fp;
        bit okv;
        logic [N-1:0] oh;
        q  = p_qty[w];
        fp = 0;
        okv = 1'b0;
        if (p_op[w] == 0) begin
            if (q <= m_stock) begin
                m_stock = m_stock - q;
                fp      = exec_price * q;
                m_sales = (m_sales + fp > 4095) ? 4095 : m_sales + fp;
                okv     = 1'b1;
            end
        end else begin
            if (m_stock + q <= 15) begin
                m_stock = m_stock + q;
                okv     = 1'b1;
            end
        end
        oh    = '0;
        oh[w] = 1'b1;
        return {oh, okv, 8'(fp), 4'(m_stock), 4'(m_price), 12'(m_sales)};
    endfunction

    task automatic issue(input int r, input int o, input int q);
        pend[r]  = 1'b1;
        p_op[r]  = o;
        p_qty[r] = q;
        bus.op[r]          = o[0];
        bus.qty[4*r +: 4]  = q[3:0];
        bus.req[r]         = 1'b1;
    endtask

    // new_price >= 0 writes that price on the EXEC edge of this transaction.
    task automatic serve(input int new_price);
        int w, old_p, hold;
        bit seen, got;
        logic [N-1:0] oh;
        w = predict();
        if (w < 0) return;
        old_p = m_price;
        if (new_price >= 0) m_price = new_price;
        exp_q.push_back(model_exec(w, old_p));
        seen = 1'b0;
        got  = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            bus.price_we = 1'b0;
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else if (!seen && bus.gnt[w] === 1'b1) begin
                seen = 1'b1;
                bus.op[w]         = ~bus.op[w];
                bus.qty[4*w +: 4] = 4'($urandom_range(0, 15));
                if (new_price >= 0) begin
                    bus.price_we = 1'b1;
                    bus.price_in = new_price[3:0];
                end
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        oh    = '0;
        oh[w] = 1'b1;
        if (got) begin
            @(negedge clk);
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("gnt_hold", 32'(bus.gnt), 32'(oh));
            hold = $urandom_range(0, 2);
            repeat (hold) @(negedge clk);
        end
        bus.req[w] = 1'b0;
        pend[w]    = 1'b0;
        m_rr       = (w + 1) % N;
        @(negedge clk);
        chk("gnt_release", 32'(bus.gnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req      = '0;
        bus.op       = '0;
        bus.qty      = '0;
        bus.price_we = 1'b0;
        bus.price_in = '0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stock", 32'(bus.stock), 32'd10);
        chk("rst_uprice", 32'(bus.uprice), 32'd3);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_sales", 32'(bus.total_sales), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ok", 32'(bus.ok), 32'd0);
        chk("rst_fprice", 32'(bus.fprice), 32'd0);

        issue(0, 0, 4);
        serve(-1);

        // Async reset in the middle of EXEC, after state has moved away from reset values.
        bus.price_we = 1'b1;
        bus.price_in = 4'd7;
        issue(0, 0, 4);
        @(negedge clk);
        bus.price_we = 1'b0;
        chk("grant_latency", 32'(bus.gnt), 32'd1);
        chk("price_write", 32'(bus.uprice), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_ok", 32'(bus.ok), 32'd0);
        chk("arst_fprice", 32'(bus.fprice), 32'd0);
        chk("arst_stock", 32'(bus.stock), 32'd10);
        chk("arst_uprice", 32'(bus.uprice), 32'd3);
        chk("arst_sales", 32'(bus.total_sales), 32'd0);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        issue(0, 0, 4);  serve(-1);
        issue(0, 0, 7);  serve(-1);
        issue(1, 1, 9);  serve(-1);
        issue(2, 1, 1);  serve(-1);

        // Everybody requesting: grants must rotate, re-requesting after each service.
        for (int r = 0; r < N; r++) issue(r, 1, 0);
        for (int k = 0; k < 5; k++) begin
            int w;
            w = predict();
            serve(-1);
            issue(w, 1, 0);
        end
        for (int k = 0; k < N; k++) serve(-1);
        issue(1, 1, 0);  serve(-1);
        issue(0, 1, 0);  issue(1, 1, 0);  issue(3, 1, 0);
        for (int k = 0; k < 3; k++) serve(-1);

        issue(0, 0, 2);  serve(15);
        issue(0, 0, 2);  serve(-1);

        for (int k = 0; k < 20; k++) begin
            issue(0, 1, 15 - m_stock);  serve(-1);
            issue(1, 0, 15);            serve(-1);
        end
        chk("sales_saturated", 32'(bus.total_sales), 32'd4095);

        for (int k = 0; k < 150; k++) begin
            bit any;
            if ($urandom_range(0, 4) == 0) begin
                m_price      = $urandom_range(0, 15);
                bus.price_we = 1'b1;
                bus.price_in = m_price[3:0];
            end
            any = 1'b0;
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1)
                    issue(r, $urandom_range(0, 1), $urandom_range(0, 15));
            end
            for (int r = 0; r < N; r++) if (pend[r]) any = 1'b1;
            if (!any) issue($urandom_range(0, N-1), $urandom_range(0, 1), $urandom_range(0, 15));
            serve(-1);
        end
        for (int k = 0; k < N; k++) serve(-1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fcims_order_controller.md
Name: fcims_order_controller

Overview:
- Sequences sell and restock transactions from N kiosk requesters onto one shared stock-count/pricing datapath for a single item.
- Round-robin arbiter grants one requester at a time. A 3-state FSM latches the request, executes it and holds the grant until release.
- Executing a request updates the stock register, computes the order price (unit price × qty) and accumulates total sales.
- Sits above the 4-bit adder/subtracter and 4×4 multiplier datapath; owns the stock and unit-price state that datapath consumes.

Parameters:
- N, 4, number of requesters (2..8)
- STOCK_INIT, 4'd10, stock value loaded at reset
- PRICE_INIT, 4'd3, unit price loaded at reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req  in  N  per-requester request; level, held until own gnt seen and done consumed
- op  in  N  per-requester operation; 0 = sell, 1 = restock
- qty  in  4*N  per-requester quantity; requester i uses qty[4i+3:4i]
- price_we  in  1  unit-price write enable
- price_in  in  4  new unit price
- gnt  out  N  one-hot grant, registered
- done  out  1  one-cycle pulse: result valid
- ok  out  1  status of last transaction (1 = accepted), valid from done until next done
- fprice  out  8  price of last accepted sell; 0 for restock or reject
- stock  out  4  current stock count
- uprice  out  4  current unit price
- total_sales  out  12  accumulated sell revenue, saturating

Behaviour:
- Reset (async, any state):
  - state=IDLE; gnt=0, done=0, ok=0, fprice=0, total_sales=0.
  - stock=STOCK_INIT, uprice=PRICE_INIT, rr pointer=0.
- IDLE:
  - If req≠0, pick the first set req at or after the rr pointer, wrapping.
  - Register gnt one-hot for the winner; latch its op and qty; go to EXEC.
  - If req=0, stay in IDLE; all outputs hold.
- EXEC (exactly one cycle), using latched op/qty and the uprice value present in this cycle:
  - Sell, qty≤stock: stock←stock−qty; fprice←uprice×qty (8-bit, exact, max 225); total_sales←min(total_sales+uprice×qty, 4095); ok←1.
  - Sell, qty>stock: no state change; fprice←0; ok←0.
  - Restock, stock+qty≤15: stock←stock+qty; fprice←0; ok←1.
  - Restock, overflow past 15: no change; fprice←0; ok←0.
  - qty=0: ok←1; stock unchanged; fprice←0.
  - done←1 for this single cycle. rr pointer←(winner+1) mod N. Go to WAIT.
- WAIT:
  - Hold gnt while req[winner]=1.
  - When req[winner]=0 at an edge: gnt←0, state←IDLE.
  - Minimum spacing between grants: 3 cycles.
- Latency: req sampled at edge k → gnt high after k; done/results high after k+1.
- Requester dropping req during EXEC: the transaction still completes, then WAIT exits on the next edge.
- Non-granted req, op and qty changes are ignored. Latched values are immune to mid-transaction changes.
- price_we: uprice←price_in at any edge.
  - If it coincides with the EXEC edge, EXEC uses the old uprice; the new value applies from the next transaction.
- Simultaneous requests: strict rotation, no starvation. Each requester waits at most N−1 transactions.
- Stock and price arithmetic are never silently truncated: an overflow or underflow is a reject (ok=0).
- Arithmetic is unsigned throughout.

Test Plan:
- Reset, then idle: stock=10, uprice=3, gnt=0, total_sales=0. Assert rst mid-EXEC → all outputs return to reset values asynchronously.
- req0 sell qty=4 → gnt=0001 next edge, then done=1, ok=1, fprice=12, stock=6, total_sales=12. Drop req0 → gnt=0 one cycle later.
- From stock=6, sell qty=7 → done, ok=0, fprice=0, stock=6. Then restock qty=9 → ok=1, stock=15. Then restock qty=1 → ok=0, stock=15.
- req=1111 held and released after each done → grant order 0,1,2,3,0; after a grant to 2 with req=1011, next grant goes to 3.
- price_we with price_in=15 on the EXEC edge of a sell qty=2 → fprice=6 (old price). Next sell qty=2 → fprice=30.
- Repeated sells of 15×15=225 with restock in between → total_sales saturates at 4095 and stays there.
